// File: rtl/repne_ctrl_ex.sv
// REPNE CMPS execute-stage sequencer: tracks ECX across first/second uop pairs and pulses loop terminate.
// Optional iteration cap enabled by defining REPNE_ITER_LIMIT_EN.
module repne_ctrl_ex #(
    parameter int unsigned COUNT_W  = 32,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EX_V,
    input  logic               EX_d2_repne_wb,
    input  logic               CS_IS_CMPS_FIRST_UOP_ALL,
    input  logic               CS_IS_CMPS_SECOND_UOP_ALL,
    input  logic [COUNT_W-1:0] EX_C,
    input  logic               alu32_zf,
    input  logic               WB_stall,
    input  logic               EX_flush,
    output logic [COUNT_W-1:0] saved_count,
    output logic               repne_busy,
    output logic               wb_repne_terminate_all,
    output logic               seq_err,
    output logic [15:0]        iter_count
);

    localparam int unsigned ITER_W = 16;

`ifdef REPNE_ITER_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_SECOND = 2'b01,
        WAIT_FIRST  = 2'b10,
        TERM        = 2'b11
    } state_t;

    state_t              state, state_nx;
    logic [COUNT_W-1:0]  count_nx;
    logic [ITER_W-1:0]   iter_nx;
    logic                err_nx;
    logic                acc_first, acc_second;
    logic [COUNT_W-1:0]  cnt_dec;
    logic [ITER_W-1:0]   iter_inc;
    logic                limit_hit;

    assign acc_first  = EX_V & EX_d2_repne_wb & CS_IS_CMPS_FIRST_UOP_ALL  & ~WB_stall;
    assign acc_second = EX_V & EX_d2_repne_wb & CS_IS_CMPS_SECOND_UOP_ALL & ~WB_stall;

    assign cnt_dec   = saved_count - COUNT_W'(1);
    assign iter_inc  = (iter_count == {ITER_W{1'b1}}) ? iter_count : iter_count + ITER_W'(1);
    assign limit_hit = LIMIT_EN && (iter_inc == ITER_W'(MAX_ITER));

    // Next-state and next-value logic; flush beats acceptance, stall freezes everything else.
    always_comb begin
        state_nx = state;
        count_nx = saved_count;
        iter_nx  = iter_count;
        err_nx   = seq_err;
        if (EX_flush) begin
            state_nx = IDLE;
            iter_nx  = '0;
        end else if (!WB_stall) begin
            case (state)
                IDLE: begin
                    if (acc_first) begin
                        iter_nx = '0;
                        if (EX_C == '0) begin
                            state_nx = TERM;
                            count_nx = '0;
                        end else begin
                            state_nx = WAIT_SECOND;
                            count_nx = EX_C;
                        end
                    end else if (acc_second) begin
                        err_nx = 1'b1;
                    end
                end
                WAIT_SECOND: begin
                    if (acc_second) begin
                        count_nx = cnt_dec;
                        iter_nx  = iter_inc;
                        if (cnt_dec == '0 || alu32_zf || limit_hit) state_nx = TERM;
                        else                                        state_nx = WAIT_FIRST;
                    end else if (acc_first) begin
                        err_nx = 1'b1;
                    end
                end
                WAIT_FIRST: begin
                    if (acc_first)       state_nx = WAIT_SECOND;
                    else if (acc_second) err_nx   = 1'b1;
                end
                TERM: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and registered outputs; busy/terminate are decoded from the next state so they stay registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state                  <= IDLE;
            saved_count            <= '0;
            iter_count             <= '0;
            seq_err                <= 1'b0;
            repne_busy             <= 1'b0;
            wb_repne_terminate_all <= 1'b0;
        end else begin
            state                  <= state_nx;
            saved_count            <= count_nx;
            iter_count             <= iter_nx;
            seq_err                <= err_nx;
            repne_busy             <= (state_nx != IDLE);
            wb_repne_terminate_all <= (state_nx == TERM);
        end
    end

endmodule
